// File: rtl/core_ctrl_ldst_pop.sv
// Register-list pop unit for load/store-multiple sequencing.
// Optional macro LDST_POP_COUNT_EN adds a registered set-bit count output.
module core_ctrl_ldst_pop #(
  parameter int NREGS = 16,
  parameter int NUM_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREGS-1:0] regs,
  output logic             valid,
  output logic [NUM_W-1:0] pop_lower,
  output logic [NUM_W-1:0] pop_upper,
  output logic [NREGS-1:0] next_lower,
  output logic [NREGS-1:0] next_upper
`ifdef LDST_POP_COUNT_EN
  ,
  output logic [NUM_W:0]   count
`endif
);

  logic             valid_d;
  logic [NUM_W-1:0] lo_d;
  logic [NUM_W-1:0] hi_d;
  logic [NREGS-1:0] nlo_d;
  logic [NREGS-1:0] nhi_d;

  // Lowest set bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    lo_d = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (regs[i]) lo_d = NUM_W'(i);
    end
  end

  // Highest set bit wins: scan upward so the last hit is the highest.
  always_comb begin
    hi_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (regs[i]) hi_d = NUM_W'(i);
    end
  end

  // Clear only the selected bit; an empty list stays empty.
  always_comb begin
    valid_d = |regs;
    nlo_d   = regs & ~(NREGS'(1) << lo_d);
    nhi_d   = regs & ~(NREGS'(1) << hi_d);
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      pop_lower  <= '0;
      pop_upper  <= '0;
      next_lower <= '0;
      next_upper <= '0;
    end else begin
      valid      <= valid_d;
      pop_lower  <= lo_d;
      pop_upper  <= hi_d;
      next_lower <= nlo_d;
      next_upper <= nhi_d;
    end
  end

`ifdef LDST_POP_COUNT_EN
  logic [NUM_W:0] cnt_d;

  // Population count of the pending list.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + (NUM_W+1)'(regs[i]);
    end
  end

  // Count register, same latency as the other outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_core_ctrl_ldst_pop.sv
// Directed table, feedback iteration and random checks
// for core_ctrl_ldst_pop.
module tb_core_ctrl_ldst_pop;

  typedef struct packed {
    logic        v;
    logic [3:0]  pl;
    logic [3:0]  pu;
    logic [15:0] nl;
    logic [15:0] nu;
    logic [4:0]  cnt;
  } out_t;

  typedef struct packed {
    logic [15:0] regs;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] regs = '0;
  logic        valid;
  logic [3:0]  pop_lower;
  logic [3:0]  pop_upper;
  logic [15:0] next_lower;
  logic [15:0] next_upper;
  logic [4:0]  cnt_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_ctrl_ldst_pop dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regs       (regs),
    .valid      (valid),
    .pop_lower  (pop_lower),
    .pop_upper  (pop_upper),
    .next_lower (next_lower),
    .next_upper (next_upper)
`ifdef LDST_POP_COUNT_EN
    ,
    .count      (cnt_w)
`endif
  );

`ifndef LDST_POP_COUNT_EN
  assign cnt_w = 5'd0;
`endif

  function automatic out_t model(input logic [15:0] r);
    out_t o;
    o = '0;
    o.v = (r != 16'h0);
    for (int i = 0; i < 16; i++) begin
      if (r[i]) begin
        o.pl = 4'(i);
        break;
      end
    end
    for (int i = 15; i >= 0; i--) begin
      if (r[i]) begin
        o.pu = 4'(i);
        break;
      end
    end
    o.nl = r & (r - 16'd1);
    o.nu = r & ~(16'd1 << o.pu);
`ifdef LDST_POP_COUNT_EN
    o.cnt = 5'($countones(r));
`endif
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o.v   = valid;
    o.pl  = pop_lower;
    o.pu  = pop_upper;
    o.nl  = next_lower;
    o.nu  = next_upper;
    o.cnt = cnt_w;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = actual();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got v=%b pl=%0d pu=%0d nl=%h nu=%h c=%0d, want v=%b pl=%0d pu=%0d nl=%h nu=%h c=%0d",
               name, act.v, act.pl, act.pu, act.nl, act.nu, act.cnt,
               exp.v, exp.pl, exp.pu, exp.nl, exp.nu, exp.cnt);
    end
  endtask

  task automatic apply(input logic [15:0] r);
    @(negedge clk);
    regs = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] c(input logic [4:0] n);
`ifdef LDST_POP_COUNT_EN
    return n;
`else
    return 5'd0 & n;
`endif
  endfunction

  vec_t vecs[7];
  out_t zero;
  int   exp_seq[4];

  initial begin
    zero = '0;
    vecs[0] = '{16'h00A4, '{1'b1, 4'd2,  4'd7,  16'h00A0, 16'h0024, c(5'd3)}};
    vecs[1] = '{16'h0000, '{1'b0, 4'd0,  4'd0,  16'h0000, 16'h0000, c(5'd0)}};
    vecs[2] = '{16'h8000, '{1'b1, 4'd15, 4'd15, 16'h0000, 16'h0000, c(5'd1)}};
    vecs[3] = '{16'hFFFF, '{1'b1, 4'd0,  4'd15, 16'hFFFE, 16'h7FFF, c(5'd16)}};
    vecs[4] = '{16'h0001, '{1'b1, 4'd0,  4'd0,  16'h0000, 16'h0000, c(5'd1)}};
    vecs[5] = '{16'h0180, '{1'b1, 4'd7,  4'd8,  16'h0100, 16'h0080, c(5'd2)}};
    vecs[6] = '{16'h5000, '{1'b1, 4'd12, 4'd14, 16'h4000, 16'h1000, c(5'd2)}};

    regs  = 16'hFFFF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", zero);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", zero);
    @(posedge clk);
    #1;
    check("release_first_edge", vecs[3].exp);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", zero);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].regs);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    exp_seq = '{0, 1, 4, 15};
    apply(16'h8013);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (valid !== 1'b1 || pop_lower !== 4'(exp_seq[i])) begin
        fails++;
        $display("FAIL iter_lower%0d: got v=%b pl=%0d, want v=1 pl=%0d",
                 i, valid, pop_lower, exp_seq[i]);
      end
      apply(next_lower);
    end
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL iter_lower_end: got v=%b, want 0", valid);
    end

    exp_seq = '{15, 4, 1, 0};
    apply(16'h8013);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (valid !== 1'b1 || pop_upper !== 4'(exp_seq[i])) begin
        fails++;
        $display("FAIL iter_upper%0d: got v=%b pu=%0d, want v=1 pu=%0d",
                 i, valid, pop_upper, exp_seq[i]);
      end
      apply(next_upper);
    end
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL iter_upper_end: got v=%b, want 0", valid);
    end

    for (int i = 0; i < 10000; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (i % 8 == 0) r = r & 16'($urandom);
      if (i % 16 == 1) r = 16'h1 << (i % 16);
      apply(r);
      if (actual() !== model(r)) check($sformatf("rand%0d_%h", i, r), model(r));
      else tests++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
